// File: rtl/mips_regfile_wb_if.sv
`default_nettype none
// ==========================================================================
// mips_regfile_wb_if : instruction/operand/result bus of the register file
// Revision 1.0
// ==========================================================================
interface mips_regfile_wb_if #(
  parameter int DW = 32,
  parameter int AW = 5
);
  logic [31:0]   ins_mem;
  logic          ins_valid;
  logic [DW-1:0] ALU_result;
  logic [DW-1:0] read_data1;
  logic [DW-1:0] read_data2;
  logic          wb_pending;
  logic [AW-1:0] wb_addr;
  logic [AW-1:0] dbg_addr;
  logic [DW-1:0] dbg_data;

  modport slave (
    input  ins_mem, ins_valid, ALU_result, dbg_addr,
    output read_data1, read_data2, wb_pending, wb_addr, dbg_data
  );

  modport master (
    output ins_mem, ins_valid, ALU_result, dbg_addr,
    input  read_data1, read_data2, wb_pending, wb_addr, dbg_data
  );
endinterface
`default_nettype wire

// File: rtl/mips_regfile_wb.sv
`default_nettype none
// ==========================================================================
// mips_regfile_wb : 32x32 MIPS register file with one-entry bypassed write-back
// Revision 1.0
// ==========================================================================
module mips_regfile_wb #(
  parameter int NREGS = 32,
  parameter int DW    = 32
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mips_regfile_wb_if.slave  bus
);
  localparam int AW = $clog2(NREGS);

  logic [5:0]    opcode;
  logic [AW-1:0] rs;
  logic [AW-1:0] rt;
  logic [AW-1:0] rd;
  logic [AW-1:0] dest;

  logic [DW-1:0] regs [NREGS];
  logic          wb_valid_q;
  logic [AW-1:0] wb_dest_q;

  logic [DW-1:0] rdata1;
  logic [DW-1:0] rdata2;
  logic [DW-1:0] dbg_rdata;
  logic          unused_ins;

  assign opcode = bus.ins_mem[31:26];
  assign rs     = bus.ins_mem[25:21];
  assign rt     = bus.ins_mem[20:16];
  assign rd     = bus.ins_mem[15:11];
  assign unused_ins = ^bus.ins_mem[10:0];

  // R-type retires into rd, every other format into rt
  assign dest = (opcode == 6'd0) ? rd : rt;

  always_ff @(posedge clk) begin
    if (!rst) begin
      wb_valid_q <= 1'b0;
      wb_dest_q  <= '0;
    end else begin
      wb_valid_q <= bus.ins_valid && (dest != '0);
      wb_dest_q  <= dest;
    end
  end

  // Retire uses the entry captured last cycle; $0 is excluded at capture
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
    end else if (wb_valid_q && (wb_dest_q != '0)) begin
      regs[wb_dest_q] <= bus.ALU_result;
    end
  end

  always_comb begin
    rdata1 = '0;
    rdata2 = '0;
    if (rst && (rs != '0)) begin
      rdata1 = (wb_valid_q && (wb_dest_q == rs)) ? bus.ALU_result : regs[rs];
    end
    if (rst && (rt != '0)) begin
      rdata2 = (wb_valid_q && (wb_dest_q == rt)) ? bus.ALU_result : regs[rt];
    end
  end

  always_comb begin
    dbg_rdata = '0;
    if (rst && (bus.dbg_addr != '0)) begin
      dbg_rdata = regs[bus.dbg_addr];
    end
  end

  assign bus.read_data1 = rdata1;
  assign bus.read_data2 = rdata2;
  assign bus.dbg_data   = dbg_rdata;
  assign bus.wb_pending = wb_valid_q;
  assign bus.wb_addr    = wb_dest_q;
endmodule
`default_nettype wire

// File: tb/tb_mips_regfile_wb.sv
`default_nettype none
// ==========================================================================
// tb_mips_regfile_wb : directed + random checks against an architectural model
// Revision 1.0
// ==========================================================================
module tb_mips_regfile_wb;
  logic clk;
  logic rst;
  int   checks;
  int   failures;

  mips_regfile_wb_if #(.DW(32), .AW(5)) bus ();

  mips_regfile_wb #(.NREGS(32), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #50 clk = ~clk;
  end

  // Architectural model: register contents plus the one outstanding result
  logic [31:0] m_regs [32];
  logic        m_pv;
  logic [4:0]  m_pd;

  logic [31:0] obs_rd1, obs_rd2, obs_dbg;
  logic        obs_pend;
  logic [4:0]  obs_addr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] rtype(input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'd0, s, t, d, 11'h020};
  endfunction

  function automatic logic [31:0] itype(input logic [5:0] op, input logic [4:0] s,
                                        input logic [4:0] t, input logic [15:0] imm);
    return {op, s, t, imm};
  endfunction

  function automatic logic [31:0] expect_read(input logic r, input logic [4:0] a, input logic [31:0] alu);
    if (!r || a == 5'd0) return 32'd0;
    if (m_pv && m_pd == a) return alu;
    return m_regs[a];
  endfunction

  // One clock cycle: drive at posedge+1, check at posedge+49, update model at edge
  task automatic step(input logic [31:0] ins, input logic v, input logic [31:0] alu,
                      input logic r, input logic [4:0] dbg, input bit sweep);
    logic [4:0] d;
    bus.ins_mem    = ins;
    bus.ins_valid  = v;
    bus.ALU_result = alu;
    bus.dbg_addr   = dbg;
    rst            = r;
    #48;
    obs_rd1  = bus.read_data1;
    obs_rd2  = bus.read_data2;
    obs_dbg  = bus.dbg_data;
    obs_pend = bus.wb_pending;
    obs_addr = bus.wb_addr;
    chk("read_data1", obs_rd1, expect_read(r, ins[25:21], alu));
    chk("read_data2", obs_rd2, expect_read(r, ins[20:16], alu));
    chk("dbg_data", obs_dbg, (r && dbg != 5'd0) ? m_regs[dbg] : 32'd0);
    chk("wb_pending", {31'd0, obs_pend}, {31'd0, m_pv});
    if (m_pv) chk("wb_addr", {27'd0, obs_addr}, {27'd0, m_pd});
    if (sweep) begin
      for (int i = 0; i < 32; i++) begin
        bus.dbg_addr = 5'(i);
        #1;
        chk("dbg_sweep", bus.dbg_data, (r && i != 0) ? m_regs[i] : 32'd0);
      end
    end
    @(posedge clk);
    if (!r) begin
      for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
      m_pv = 1'b0;
      m_pd = 5'd0;
    end else begin
      if (m_pv && m_pd != 5'd0) m_regs[m_pd] = alu;
      d    = (ins[31:26] == 6'd0) ? ins[15:11] : ins[20:16];
      m_pv = v && (d != 5'd0);
      m_pd = d;
    end
    #1;
  endtask

  initial begin
    logic [31:0] ins;
    logic [31:0] alu;
    logic        v;
    logic        r;
    checks   = 0;
    failures = 0;
    rst            = 1'b0;
    bus.ins_mem    = 32'd0;
    bus.ins_valid  = 1'b0;
    bus.ALU_result = 32'd0;
    bus.dbg_addr   = 5'd0;

    // Reset: two cycles low, the first edge brings the design to a known state
    @(posedge clk);
    for (int i = 0; i < 32; i++) m_regs[i] = 32'd0;
    m_pv = 1'b0;
    m_pd = 5'd0;
    #1;
    step(32'd0, 1'b0, $urandom, 1'b0, 5'd0, 1'b0);
    step(32'd0, 1'b0, $urandom, 1'b1, 5'd0, 1'b1);
    chk("pending_after_release", {31'd0, obs_pend}, 32'd0);

    // R-type write to $5
    step(rtype(5'd1, 5'd2, 5'd5), 1'b1, $urandom, 1'b1, 5'd0, 1'b0);
    step(32'd0, 1'b0, 32'h0000_1234, 1'b1, 5'd5, 1'b0);
    chk("rtype_pending", {31'd0, obs_pend}, 32'd1);
    chk("rtype_addr", {27'd0, obs_addr}, 32'd5);
    step(32'd0, 1'b0, $urandom, 1'b1, 5'd5, 1'b0);
    chk("rtype_dbg5", obs_dbg, 32'h0000_1234);

    // I-type writes rt=9, not the rd field (3)
    step(itype(6'h08, 5'd1, 5'd9, 16'h1800), 1'b1, $urandom, 1'b1, 5'd0, 1'b0);
    step(32'd0, 1'b0, 32'hFFFF_FFF0, 1'b1, 5'd0, 1'b0);
    step(32'd0, 1'b0, $urandom, 1'b1, 5'd9, 1'b0);
    chk("itype_dbg9", obs_dbg, 32'hFFFF_FFF0);
    step(32'd0, 1'b0, $urandom, 1'b1, 5'd3, 1'b0);
    chk("itype_dbg3", obs_dbg, 32'd0);

    // Back-to-back bypass on $7, then a plain array read
    step(rtype(5'd0, 5'd0, 5'd7), 1'b1, $urandom, 1'b1, 5'd0, 1'b0);
    step(rtype(5'd7, 5'd7, 5'd1), 1'b1, 32'hDEAD_BEEF, 1'b1, 5'd0, 1'b0);
    chk("bypass_rd1", obs_rd1, 32'hDEAD_BEEF);
    chk("bypass_rd2", obs_rd2, 32'hDEAD_BEEF);
    step(rtype(5'd7, 5'd0, 5'd2), 1'b0, $urandom, 1'b1, 5'd0, 1'b0);
    chk("array_rd1", obs_rd1, 32'hDEAD_BEEF);

    // $0 is never written nor bypassed
    step(rtype(5'd1, 5'd2, 5'd0), 1'b1, $urandom, 1'b1, 5'd0, 1'b0);
    step(rtype(5'd0, 5'd0, 5'd0), 1'b0, 32'h5555_5555, 1'b1, 5'd0, 1'b0);
    chk("zero_pending", {31'd0, obs_pend}, 32'd0);
    chk("zero_rd1_n1", obs_rd1, 32'd0);
    step(rtype(5'd0, 5'd3, 5'd0), 1'b0, 32'h5555_5555, 1'b1, 5'd0, 1'b0);
    chk("zero_rd1_n2", obs_rd1, 32'd0);
    chk("zero_dbg0", obs_dbg, 32'd0);

    // Invalid slot leaves $4 untouched
    step(rtype(5'd1, 5'd2, 5'd4), 1'b1, $urandom, 1'b1, 5'd0, 1'b0);
    step(32'd0, 1'b0, 32'h0000_4444, 1'b1, 5'd0, 1'b0);
    step(rtype(5'd1, 5'd2, 5'd4), 1'b0, $urandom, 1'b1, 5'd0, 1'b0);
    step(32'd0, 1'b0, 32'h0000_0BAD, 1'b1, 5'd4, 1'b0);
    chk("invalid_pending", {31'd0, obs_pend}, 32'd0);
    step(32'd0, 1'b0, $urandom, 1'b1, 5'd4, 1'b0);
    chk("invalid_dbg4", obs_dbg, 32'h0000_4444);

    // Reset at the retire edge drops the pending write
    step(rtype(5'd1, 5'd2, 5'd4), 1'b1, $urandom, 1'b1, 5'd0, 1'b0);
    step(32'd0, 1'b0, 32'hA5A5_A5A5, 1'b0, 5'd4, 1'b0);
    step(32'd0, 1'b0, $urandom, 1'b1, 5'd4, 1'b0);
    chk("reset_mid_dbg4", obs_dbg, 32'd0);
    chk("reset_mid_pending", {31'd0, obs_pend}, 32'd0);

    // Random traffic, biased toward a few registers to exercise the bypass
    for (int n = 0; n < 400; n++) begin
      ins = $urandom;
      if ($urandom_range(0, 1) == 0) ins[31:26] = 6'd0;
      if ($urandom_range(0, 1) == 0) begin
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
      end
      v   = ($urandom_range(0, 3) != 0);
      r   = ($urandom_range(0, 29) != 0);
      alu = $urandom;
      step(ins, v, alu, r, 5'($urandom_range(0, 31)), (n % 50) == 49);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
